// File: rtl/pacman_pkg.sv
// Shared types and scan-code constants for the Pac-Man keyboard path.
package pacman_pkg;

    // Direction encoding used by cur_dir, the turn FIFO and the game FSM.
    typedef enum logic [2:0] {
        UP       = 3'b000,
        DOWN     = 3'b001,
        LEFT     = 3'b010,
        RIGHT    = 3'b011,
        DIR_NONE = 3'b111
    } dir_t;

    // WASD set (channel 0, non-extended codes)
    localparam logic [7:0] SC_W = 8'h1D;
    localparam logic [7:0] SC_S = 8'h1B;
    localparam logic [7:0] SC_A = 8'h1C;
    localparam logic [7:0] SC_D = 8'h23;

    // Arrow set (channel 1, E0-extended codes)
    localparam logic [7:0] SC_ARROW_UP    = 8'h75;
    localparam logic [7:0] SC_ARROW_DOWN  = 8'h72;
    localparam logic [7:0] SC_ARROW_LEFT  = 8'h6B;
    localparam logic [7:0] SC_ARROW_RIGHT = 8'h74;

    // Prefix bytes consumed by the keyboard decoder upstream.
    localparam logic [7:0] EXT_PREFIX   = 8'hE0;
    localparam logic [7:0] BREAK_PREFIX = 8'hF0;

    // Highest-priority held key; held mask bit i corresponds to direction code i.
    function automatic dir_t first_held(input logic [3:0] mask);
        dir_t d;
        d = DIR_NONE;
        if (mask[0])      d = UP;
        else if (mask[1]) d = DOWN;
        else if (mask[2]) d = LEFT;
        else if (mask[3]) d = RIGHT;
        return d;
    endfunction

endpackage

// File: rtl/dir_fifo.sv
// Registered turn-request FIFO. A push while full is accepted only if a pop
// happens in the same cycle; there is no empty-to-output bypass.
module dir_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 3,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             accepted,
    output logic             dropped
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             pop_ok;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

    // Next-state for storage, pointers and occupancy; flush overrides everything.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        pop_ok   = pop & ~empty & ~flush;
        accepted = push & ~flush & (~full | pop_ok);
        dropped  = push & ~flush & full & ~pop_ok;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (accepted) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(accepted) - CW'(pop_ok);
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/key_direction_queue.sv
// Converts decoded key events into per-player direction levels and a queue of
// buffered turn requests. Channel 0 = WASD, channel 1 = E0-extended arrows.
// Handshake: an entry leaves the queue on a rising edge where dir_valid and
// dir_ready are both high; dir_ready while empty has no effect.
module key_direction_queue
    import pacman_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int FIFO_DEPTH = 4,
    parameter bit STICKY     = 1'b1,
    parameter bit DROP_DUP   = 1'b1,
    localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 key_valid,
    input  logic [7:0]           key_code,
    input  logic                 key_extended,
    input  logic                 key_release,
    input  logic                 flush,
    output logic [3*NUM_CH-1:0]  cur_dir,
    output logic [NUM_CH-1:0]    dir_valid,
    input  logic [NUM_CH-1:0]    dir_ready,
    output logic [3*NUM_CH-1:0]  dir_data,
    output logic [CW*NUM_CH-1:0] fifo_count,
    output logic [NUM_CH-1:0]    overflow
);

    logic       hit0, hit1;
    logic [1:0] ev_idx;
    dir_t       ev_dir;

    // Map a key event to a channel and a direction index; unmapped codes hit nothing.
    always_comb begin
        hit0   = 1'b0;
        hit1   = 1'b0;
        ev_idx = 2'd0;
        if (key_valid) begin
            if (!key_extended) begin
                unique case (key_code)
                    SC_W:    begin hit0 = 1'b1; ev_idx = 2'd0; end
                    SC_S:    begin hit0 = 1'b1; ev_idx = 2'd1; end
                    SC_A:    begin hit0 = 1'b1; ev_idx = 2'd2; end
                    SC_D:    begin hit0 = 1'b1; ev_idx = 2'd3; end
                    default: ;
                endcase
            end else if (NUM_CH > 1) begin
                unique case (key_code)
                    SC_ARROW_UP:    begin hit1 = 1'b1; ev_idx = 2'd0; end
                    SC_ARROW_DOWN:  begin hit1 = 1'b1; ev_idx = 2'd1; end
                    SC_ARROW_LEFT:  begin hit1 = 1'b1; ev_idx = 2'd2; end
                    SC_ARROW_RIGHT: begin hit1 = 1'b1; ev_idx = 2'd3; end
                    default: ;
                endcase
            end
        end
        ev_dir = dir_t'({1'b0, ev_idx});
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [3:0]  held_q, held_d;
        dir_t        cur_q, cur_d;
        dir_t        last_q, last_d;
        logic        ovf_q, ovf_d;
        logic        ev_hit, push_req;
        logic [2:0]  head;
        logic        fifo_empty, fifo_full, push_acc, push_drop;
        logic [CW-1:0] count;

        assign ev_hit = (g == 0) ? hit0 : hit1;

        // Held mask, direction level, dedup register and overflow pulse.
        always_comb begin
            held_d   = held_q;
            cur_d    = cur_q;
            last_d   = last_q;
            push_req = 1'b0;
            if (flush) begin
                held_d = '0;
                cur_d  = DIR_NONE;
                last_d = DIR_NONE;
            end else if (ev_hit) begin
                if (!key_release) begin
                    // A make on an already-held key is typematic repeat and is ignored.
                    if (!held_q[ev_idx]) begin
                        held_d[ev_idx] = 1'b1;
                        cur_d          = ev_dir;
                        push_req       = !(DROP_DUP && (last_q == ev_dir));
                    end
                end else begin
                    held_d[ev_idx] = 1'b0;
                    if (cur_q == ev_dir) begin
                        if (|held_d)      cur_d = first_held(held_d);
                        else if (!STICKY) cur_d = DIR_NONE;
                    end
                end
            end
            if (push_acc) last_d = ev_dir;
            ovf_d = push_drop;
        end

        // Channel registers with asynchronous active-low reset.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                held_q <= '0;
                cur_q  <= DIR_NONE;
                last_q <= DIR_NONE;
                ovf_q  <= 1'b0;
            end else begin
                held_q <= held_d;
                cur_q  <= cur_d;
                last_q <= last_d;
                ovf_q  <= ovf_d;
            end
        end

        dir_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(3)) u_fifo (
            .clk      (clk),
            .rst      (rst),
            .flush    (flush),
            .push     (push_req),
            .push_data(ev_dir),
            .pop      (dir_ready[g]),
            .head     (head),
            .count    (count),
            .full     (fifo_full),
            .empty    (fifo_empty),
            .accepted (push_acc),
            .dropped  (push_drop)
        );

        assign cur_dir[3*g +: 3]     = cur_q;
        assign dir_valid[g]          = ~fifo_empty;
        assign dir_data[3*g +: 3]    = fifo_empty ? DIR_NONE : head;
        assign fifo_count[CW*g +: CW] = count;
        assign overflow[g]           = ovf_q;
    end

endmodule

// File: tb/tb_key_direction_queue.sv
// Directed bench for key_direction_queue: default instance plus a STICKY=0
// instance and a single-channel instance sharing the same stimulus.
module tb_key_direction_queue;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       key_valid = 1'b0;
    logic [7:0] key_code = 8'h00;
    logic       key_extended = 1'b0;
    logic       key_release = 1'b0;
    logic       flush = 1'b0;
    logic [1:0] dir_ready = 2'b00;

    logic [5:0] cur_dir, dir_data, fifo_count;
    logic [1:0] dir_valid, overflow;
    logic [5:0] cur_dir_n, dir_data_n, fifo_count_n;
    logic [1:0] dir_valid_n, overflow_n;
    logic [2:0] cur_dir_1, dir_data_1, fifo_count_1;
    logic       dir_valid_1, overflow_1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    key_direction_queue dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .key_extended(key_extended), .key_release(key_release), .flush(flush),
        .cur_dir(cur_dir), .dir_valid(dir_valid), .dir_ready(dir_ready),
        .dir_data(dir_data), .fifo_count(fifo_count), .overflow(overflow)
    );

    key_direction_queue #(.STICKY(1'b0)) dut_ns (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .key_extended(key_extended), .key_release(key_release), .flush(flush),
        .cur_dir(cur_dir_n), .dir_valid(dir_valid_n), .dir_ready(dir_ready),
        .dir_data(dir_data_n), .fifo_count(fifo_count_n), .overflow(overflow_n)
    );

    key_direction_queue #(.NUM_CH(1)) dut_1 (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .key_extended(key_extended), .key_release(key_release), .flush(flush),
        .cur_dir(cur_dir_1), .dir_valid(dir_valid_1), .dir_ready(dir_ready[0]),
        .dir_data(dir_data_1), .fifo_count(fifo_count_1), .overflow(overflow_1)
    );

    // One key event held for one cycle; returns at the following falling edge.
    task automatic send(input logic [7:0] code, input logic ext, input logic rel,
                        input logic rdy, input logic fl);
        @(negedge clk);
        key_valid = 1'b1; key_code = code; key_extended = ext; key_release = rel;
        dir_ready[0] = rdy; flush = fl;
        @(negedge clk);
        key_valid = 1'b0; key_extended = 1'b0; key_release = 1'b0;
        dir_ready = 2'b00; flush = 1'b0;
    endtask

    task automatic do_flush();
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (cur_dir !== 6'b111111) begin errors++; $display("FAIL reset_cur_dir: got %b exp 111111", cur_dir); end
        checks++; if (dir_valid !== 2'b00) begin errors++; $display("FAIL reset_dir_valid: got %b exp 00", dir_valid); end
        checks++; if (dir_data !== 6'b111111) begin errors++; $display("FAIL reset_dir_data: got %b exp 111111", dir_data); end
        checks++; if (fifo_count !== 6'd0) begin errors++; $display("FAIL reset_count: got %0d exp 0", fifo_count); end
        checks++; if (overflow !== 2'b00) begin errors++; $display("FAIL reset_overflow: got %b exp 00", overflow); end
    endtask

    task automatic test_priority();
        do_flush();
        send(8'h1D, 0, 0, 0, 0);
        checks++; if (cur_dir[2:0] !== 3'b000) begin errors++; $display("FAIL prio_cur_up: got %b exp 000", cur_dir[2:0]); end
        send(8'h23, 0, 0, 0, 0);
        checks++; if (cur_dir[2:0] !== 3'b011) begin errors++; $display("FAIL prio_cur_right: got %b exp 011", cur_dir[2:0]); end
        send(8'h23, 0, 1, 0, 0);
        checks++; if (cur_dir[2:0] !== 3'b000) begin errors++; $display("FAIL prio_cur_back_up: got %b exp 000", cur_dir[2:0]); end
        checks++; if (fifo_count[2:0] !== 3'd2) begin errors++; $display("FAIL prio_count: got %0d exp 2", fifo_count[2:0]); end
        checks++; if (dir_data[2:0] !== 3'b000 || dir_valid[0] !== 1'b1) begin errors++; $display("FAIL prio_head: got %b/%b exp 000/1", dir_data[2:0], dir_valid[0]); end
        checks++; if (cur_dir[5:3] !== 3'b111 || fifo_count[5:3] !== 3'd0) begin errors++; $display("FAIL prio_ch1_idle: got %b/%0d exp 111/0", cur_dir[5:3], fifo_count[5:3]); end
        dir_ready[0] = 1'b1;
        @(negedge clk);
        dir_ready[0] = 1'b0;
        checks++; if (dir_data[2:0] !== 3'b011 || fifo_count[2:0] !== 3'd1) begin errors++; $display("FAIL prio_pop: got %b/%0d exp 011/1", dir_data[2:0], fifo_count[2:0]); end
    endtask

    task automatic test_typematic();
        do_flush();
        repeat (3) send(8'h1C, 0, 0, 0, 0);
        checks++; if (fifo_count[2:0] !== 3'd1) begin errors++; $display("FAIL typ_count: got %0d exp 1", fifo_count[2:0]); end
        checks++; if (cur_dir[2:0] !== 3'b010 || dir_data[2:0] !== 3'b010) begin errors++; $display("FAIL typ_left: got %b/%b exp 010/010", cur_dir[2:0], dir_data[2:0]); end
        send(8'h1C, 0, 1, 0, 0);
        checks++; if (cur_dir[2:0] !== 3'b010) begin errors++; $display("FAIL typ_sticky: got %b exp 010", cur_dir[2:0]); end
        checks++; if (cur_dir_n[2:0] !== 3'b111) begin errors++; $display("FAIL typ_nonsticky: got %b exp 111", cur_dir_n[2:0]); end
    endtask

    task automatic test_overflow();
        logic [2:0] exp_seq [4];
        exp_seq[0] = 3'b001; exp_seq[1] = 3'b000; exp_seq[2] = 3'b001; exp_seq[3] = 3'b000;
        do_flush();
        for (int i = 0; i < 4; i++) begin
            send((i % 2 == 0) ? 8'h1D : 8'h1B, 0, 0, 0, 0);
            send((i % 2 == 0) ? 8'h1D : 8'h1B, 0, 1, 0, 0);
        end
        checks++; if (fifo_count[2:0] !== 3'd4) begin errors++; $display("FAIL ovf_full: got %0d exp 4", fifo_count[2:0]); end
        checks++; if (overflow[0] !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b exp 0", overflow[0]); end
        send(8'h1D, 0, 0, 0, 0);
        checks++; if (overflow[0] !== 1'b1 || fifo_count[2:0] !== 3'd4) begin errors++; $display("FAIL ovf_pulse: got %b/%0d exp 1/4", overflow[0], fifo_count[2:0]); end
        @(negedge clk);
        checks++; if (overflow[0] !== 1'b0) begin errors++; $display("FAIL ovf_one_cycle: got %b exp 0", overflow[0]); end
        send(8'h1D, 0, 1, 0, 0);
        send(8'h1D, 0, 0, 1, 0);
        checks++; if (overflow[0] !== 1'b0 || fifo_count[2:0] !== 3'd4) begin errors++; $display("FAIL ovf_push_pop: got %b/%0d exp 0/4", overflow[0], fifo_count[2:0]); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (dir_data[2:0] !== exp_seq[i]) begin errors++; $display("FAIL ovf_drain%0d: got %b exp %b", i, dir_data[2:0], exp_seq[i]); end
            dir_ready[0] = 1'b1;
            @(negedge clk);
            dir_ready[0] = 1'b0;
        end
        dir_ready[0] = 1'b1;
        @(negedge clk);
        dir_ready[0] = 1'b0;
        checks++; if (fifo_count[2:0] !== 3'd0 || dir_valid[0] !== 1'b0 || dir_data[2:0] !== 3'b111) begin errors++; $display("FAIL ovf_empty: got %0d/%b/%b exp 0/0/111", fifo_count[2:0], dir_valid[0], dir_data[2:0]); end
    endtask

    task automatic test_extended();
        do_flush();
        send(8'h75, 1, 0, 0, 0);
        checks++; if (cur_dir_n[5:3] !== 3'b000 || fifo_count_n[5:3] !== 3'd1) begin errors++; $display("FAIL ext_ch1_up: got %b/%0d exp 000/1", cur_dir_n[5:3], fifo_count_n[5:3]); end
        checks++; if (cur_dir_n[2:0] !== 3'b111 || fifo_count_n[2:0] !== 3'd0) begin errors++; $display("FAIL ext_ch0_idle: got %b/%0d exp 111/0", cur_dir_n[2:0], fifo_count_n[2:0]); end
        checks++; if (cur_dir_1 !== 3'b111 || dir_valid_1 !== 1'b0) begin errors++; $display("FAIL ext_single_ch: got %b/%b exp 111/0", cur_dir_1, dir_valid_1); end
        send(8'h75, 1, 1, 0, 0);
        checks++; if (cur_dir_n[5:3] !== 3'b111) begin errors++; $display("FAIL ext_release_none: got %b exp 111", cur_dir_n[5:3]); end
        checks++; if (cur_dir[5:3] !== 3'b000) begin errors++; $display("FAIL ext_release_sticky: got %b exp 000", cur_dir[5:3]); end
    endtask

    task automatic test_flush_reset();
        do_flush();
        send(8'h1D, 0, 0, 0, 0); send(8'h1D, 0, 1, 0, 0);
        send(8'h1B, 0, 0, 0, 0); send(8'h1B, 0, 1, 0, 0);
        send(8'h1D, 0, 0, 0, 0);
        checks++; if (fifo_count[2:0] !== 3'd3) begin errors++; $display("FAIL fl_queued: got %0d exp 3", fifo_count[2:0]); end
        send(8'h1B, 0, 0, 1, 1);
        checks++; if (fifo_count !== 6'd0 || dir_valid !== 2'b00) begin errors++; $display("FAIL fl_empty: got %0d/%b exp 0/00", fifo_count, dir_valid); end
        checks++; if (cur_dir !== 6'b111111 || dir_data !== 6'b111111) begin errors++; $display("FAIL fl_dirs: got %b/%b exp 111111/111111", cur_dir, dir_data); end
        send(8'h1D, 0, 0, 0, 0);
        checks++; if (fifo_count[2:0] !== 3'd1 || dir_data[2:0] !== 3'b000) begin errors++; $display("FAIL fl_last_cleared: got %0d/%b exp 1/000", fifo_count[2:0], dir_data[2:0]); end
        send(8'h23, 0, 0, 0, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++; if (fifo_count !== 6'd0 || dir_valid !== 2'b00) begin errors++; $display("FAIL rst_async_fifo: got %0d/%b exp 0/00", fifo_count, dir_valid); end
        checks++; if (cur_dir !== 6'b111111 || dir_data !== 6'b111111) begin errors++; $display("FAIL rst_async_dirs: got %b/%b exp 111111/111111", cur_dir, dir_data); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (fifo_count !== 6'd0 || cur_dir !== 6'b111111) begin errors++; $display("FAIL rst_release: got %0d/%b exp 0/111111", fifo_count, cur_dir); end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_typematic();
        test_overflow();
        test_extended();
        test_flush_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
